// File: rtl/wide_add_seq_if.sv
// Operand, result and slice-adder signals of the serial wide adder.
// Latency: none, pure signal bundle.
// Backpressure: valid/ready on the operand and result sides; the slice side is combinational.
interface wide_add_seq_if #(
  parameter int SliceW = 8,
  parameter int Slices = 4
);
  localparam int W = SliceW * Slices;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic              in_ci;

  logic [SliceW-1:0] slice_a;
  logic [SliceW-1:0] slice_b;
  logic              slice_ci;
  logic [SliceW-1:0] slice_s;
  logic              slice_co;

  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_sum;
  logic              out_co;
  logic              out_ovf;
  logic              busy;

  // Adder side.
  modport slave (
    input  in_valid, in_a, in_b, in_ci, slice_s, slice_co, out_ready,
    output in_ready, slice_a, slice_b, slice_ci, out_valid, out_sum, out_co, out_ovf, busy
  );

  // Producer/consumer and slice-adder side.
  modport master (
    output in_valid, in_a, in_b, in_ci, slice_s, slice_co, out_ready,
    input  in_ready, slice_a, slice_b, slice_ci, out_valid, out_sum, out_co, out_ovf, busy
  );
endinterface

// File: rtl/wide_add_seq.sv
// Wide adder that reuses one external SliceW-bit adder, one slice per cycle, LSB first.
// Latency: accept edge 0, out_valid first high after edge Slices+1, independent of operands.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module wide_add_seq #(
  parameter int SliceW = 8,
  parameter int Slices = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  wide_add_seq_if.slave   bus
);
  localparam int W    = SliceW * Slices;
  localparam int CntW = (Slices > 1) ? $clog2(Slices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Slices - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [W-1:0]    out_sum_q, out_sum_d;
  logic            out_co_q, out_co_d;
  logic            out_ovf_q, out_ovf_d;
  logic            out_valid_q, out_valid_d;

  // Next-state: accept in IDLE, one slice per RUN cycle, then present and hold the result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    out_sum_d   = out_sum_q;
    out_co_d    = out_co_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(cnt_q)*SliceW +: SliceW] = bus.slice_s;
        carry_d = bus.slice_co;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Result registers are loaded here so they are already stable when out_valid rises.
          cnt_d     = '0;
          state_d   = DONE;
          out_sum_d = sum_d;
          out_co_d  = bus.slice_co;
          out_ovf_d = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
        end
      end
      DONE: begin
        // First DONE cycle raises out_valid; afterwards wait for the consumer.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      out_sum_q   <= '0;
      out_co_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      out_sum_q   <= out_sum_d;
      out_co_q    <= out_co_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // in_ready depends only on state, so out_ready never reaches it combinationally.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_co    = out_co_q;
  assign bus.out_ovf   = out_ovf_q;

  // Slice adder operands are only live in RUN.
  assign bus.slice_a  = (state_q == RUN) ? a_q[int'(cnt_q)*SliceW +: SliceW] : '0;
  assign bus.slice_b  = (state_q == RUN) ? b_q[int'(cnt_q)*SliceW +: SliceW] : '0;
  assign bus.slice_ci = (state_q == RUN) ? carry_q : 1'b0;
endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq with a behavioural 8-bit slice adder.
// Latency: checks the 5-cycle accept-to-valid timing for default parameters.
// Backpressure: exercises held results, ignored operands and random out_ready stalls.
module tb_wide_add_seq;
  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [7:0] rec_a   [8];
  logic       rec_ci  [8];
  logic       rec_rdy [8];

  wide_add_seq_if #(.SliceW(8), .Slices(4)) bus ();

  wide_add_seq #(.SliceW(8), .Slices(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural slice adder.
  assign {bus.slice_co, bus.slice_s} = {1'b0, bus.slice_a} + {1'b0, bus.slice_b} + {8'd0, bus.slice_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Runs one addition; caller is #1 after a rising edge. Result is released after 'stall' extra cycles.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ci, input int stall,
                       output logic [31:0] s, output logic co, output logic ovf,
                       output int lat, output bit tmo);
    int guard;
    int ncyc;
    tmo = 1'b0; lat = 0; s = '0; co = 1'b0; ovf = 1'b0;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) begin tmo = 1'b1; return; end
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_ci = ci;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_a = $urandom; bus.in_b = $urandom; bus.in_ci = 1'($urandom);
    ncyc = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      if (ncyc < 8) begin
        rec_a[ncyc] = bus.slice_a; rec_ci[ncyc] = bus.slice_ci; rec_rdy[ncyc] = bus.in_ready;
      end
      ncyc++;
      @(posedge clk); #1; lat++;
    end
    if (lat >= 50) begin tmo = 1'b1; return; end
    s = bus.out_sum; co = bus.out_co; ovf = bus.out_ovf;
    repeat (stall) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_ci = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== 32'h0) begin n_err++; $display("FAIL reset_out_sum: got %h need 0", bus.out_sum); end
    n_cmp++; if ({bus.out_co, bus.out_ovf} !== 2'b00) begin n_err++; $display("FAIL reset_co_ovf: got %b need 00", {bus.out_co, bus.out_ovf}); end
    n_cmp++; if ({bus.slice_a, bus.slice_b, bus.slice_ci} !== 17'h0) begin n_err++; $display("FAIL reset_slice: got %h need 0", {bus.slice_a, bus.slice_b, bus.slice_ci}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready); end
  endtask

  // Three directed additions covering carry ripple, signed overflow and carry-in.
  task automatic test_directed();
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic        cv [3];
    logic [31:0] s;
    logic        co, ovf;
    logic [32:0] ref_sum;
    longint      sr;
    logic        ref_ovf;
    int          lat;
    bit          tmo;
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'h0000_0001; cv[0] = 1'b0;
    av[1] = 32'h7FFF_FFFF; bv[1] = 32'h0000_0001; cv[1] = 1'b0;
    av[2] = 32'h0000_00FF; bv[2] = 32'h0000_0000; cv[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], cv[i], 0, s, co, ovf, lat, tmo);
      ref_sum = {1'b0, av[i]} + {1'b0, bv[i]} + {32'd0, cv[i]};
      sr = longint'($signed(av[i])) + longint'($signed(bv[i])) + longint'(cv[i]);
      ref_ovf = (sr > MaxS) || (sr < MinS);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL dir%0d_timeout: got timeout need out_valid", i); end
      n_cmp++; if ({co, s} !== ref_sum) begin n_err++; $display("FAIL dir%0d_sum: got %b_%h need %b_%h", i, co, s, ref_sum[32], ref_sum[31:0]); end
      n_cmp++; if (ovf !== ref_ovf) begin n_err++; $display("FAIL dir%0d_ovf: got %b need %b", i, ovf, ref_ovf); end
      n_cmp++; if (lat != 5) begin n_err++; $display("FAIL dir%0d_latency: got %0d need 5", i, lat); end
      n_cmp++; if (rec_rdy[0] !== 1'b0) begin n_err++; $display("FAIL dir%0d_in_ready_run: got %b need 0", i, rec_rdy[0]); end
    end
    // Last operation was 0xFF + 0 + 1: slice 0 must see ci=1 and produce a carry into slice 1.
    n_cmp++; if (rec_a[0] !== 8'hFF) begin n_err++; $display("FAIL ci_slice_a0: got %h need ff", rec_a[0]); end
    n_cmp++; if (rec_ci[0] !== 1'b1) begin n_err++; $display("FAIL ci_slice_ci0: got %b need 1", rec_ci[0]); end
    n_cmp++; if (rec_ci[1] !== 1'b1) begin n_err++; $display("FAIL ci_slice_ci1: got %b need 1", rec_ci[1]); end
    n_cmp++; if (rec_ci[2] !== 1'b0) begin n_err++; $display("FAIL ci_slice_ci2: got %b need 0", rec_ci[2]); end
    n_cmp++; if (rec_ci[4] !== 1'b0) begin n_err++; $display("FAIL ci_slice_done: got %b need 0", rec_ci[4]); end
  endtask

  // Result held under backpressure, operands offered during DONE are ignored, back-to-back accept.
  task automatic test_hold_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [32:0] ref1, ref2;
    int          guard;
    a1 = 32'h1234_5678; b1 = 32'h8111_1111;
    a2 = 32'hDEAD_BEEF; b2 = 32'h0101_0101;
    ref1 = {1'b0, a1} + {1'b0, b1};
    ref2 = {1'b0, a2} + {1'b0, b2} + 33'd1;
    bus.in_valid = 1'b1; bus.in_a = a1; bus.in_b = b1; bus.in_ci = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    n_cmp++; if (guard >= 50) begin n_err++; $display("FAIL hold_timeout: got timeout need out_valid"); end
    bus.in_valid = 1'b1; bus.in_a = a2; bus.in_b = b2; bus.in_ci = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL hold%0d_valid: got %b need 1", c, bus.out_valid); end
      n_cmp++; if ({bus.out_co, bus.out_sum} !== ref1) begin n_err++; $display("FAIL hold%0d_sum: got %b_%h need %b_%h", c, bus.out_co, bus.out_sum, ref1[32], ref1[31:0]); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d_in_ready: got %b need 0", c, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b need 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b need 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy: got %b need 1", bus.busy); end
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    n_cmp++; if (guard != 5) begin n_err++; $display("FAIL b2b_latency: got %0d need 5", guard); end
    n_cmp++; if ({bus.out_co, bus.out_sum} !== ref2) begin n_err++; $display("FAIL b2b_sum: got %b_%h need %b_%h", bus.out_co, bus.out_sum, ref2[32], ref2[31:0]); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Reset mid-RUN discards the operation and never produces a result.
  task automatic test_reset_in_run();
    bit seen_valid;
    bus.in_valid = 1'b1; bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'h0000_0001; bus.in_ci = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_run_busy: got %b need 0", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_run_in_ready: got %b need 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_run_valid: got %b need 0", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== 32'h0) begin n_err++; $display("FAIL rst_run_sum: got %h need 0", bus.out_sum); end
    seen_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
    end
    n_cmp++; if (seen_valid) begin n_err++; $display("FAIL rst_run_stale: got out_valid pulse need none"); end
  endtask

  // Random operands, idle gaps and consumer stalls against arithmetic reference.
  task automatic test_random();
    logic [31:0] a, b, s;
    logic        ci, co, ovf, ref_ovf;
    logic [32:0] ref_sum;
    longint      sr;
    int          lat;
    bit          tmo;
    for (int t = 0; t < 1000; t++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
      if (t % 50 == 0) a = 32'hFFFF_FFFF;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_op(a, b, ci, int'($urandom_range(0, 3)), s, co, ovf, lat, tmo);
      ref_sum = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      sr = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      ref_ovf = (sr > MaxS) || (sr < MinS);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL rnd%0d_timeout: got timeout need out_valid", t); end
      n_cmp++; if ({co, s} !== ref_sum) begin n_err++; $display("FAIL rnd%0d_sum: a=%h b=%h ci=%b got %b_%h need %b_%h", t, a, b, ci, co, s, ref_sum[32], ref_sum[31:0]); end
      n_cmp++; if (ovf !== ref_ovf) begin n_err++; $display("FAIL rnd%0d_ovf: a=%h b=%h got %b need %b", t, a, b, ovf, ref_ovf); end
      n_cmp++; if (lat != 5) begin n_err++; $display("FAIL rnd%0d_latency: got %0d need 5", t, lat); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_hold_back_to_back();
    test_reset_in_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 The block SHALL have parameter SliceW, default 8, giving the bit width of one adder slice.
REQ-002 The block SHALL have parameter Slices, default 4, giving the number of slices per operand; W = SliceW*Slices (default 32).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_ci  in  1  carry-in.
- slice_a  out  SliceW  current A slice driven to the external slice adder.
- slice_b  out  SliceW  current B slice driven to the external slice adder.
- slice_ci  out  1  carry into the current slice.
- slice_s  in  SliceW  sum returned by the slice adder, combinational from slice_a/slice_b/slice_ci.
- slice_co  in  1  carry-out returned by the slice adder.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W  full sum.
- out_co  out  1  carry-out of the MSB slice.
- out_ovf  out  1  two's-complement signed overflow.
- busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-006 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-007 An input handshake (in_valid & in_ready) SHALL latch in_a, in_b and in_ci, clear slice index cnt to 0, load carry_reg with in_ci, and move IDLE->RUN.
REQ-008 In RUN, the slice outputs SHALL be driven as follows:
- slice_a = a_reg[cnt*SliceW +: SliceW]
- slice_b = b_reg[cnt*SliceW +: SliceW]
- slice_ci = carry_reg
REQ-009 Each RUN cycle SHALL write slice_s into sum_reg[cnt*SliceW +: SliceW], load carry_reg with slice_co, and increment cnt.
REQ-010 When cnt == Slices-1 in RUN, the FSM SHALL move RUN->DONE at that edge, with the final slice_co stored as out_co.
REQ-011 Latency: with the accept at edge 0, out_valid SHALL first be 1 after edge Slices+1 (cycle 5 for the defaults).
REQ-012 out_ovf SHALL equal (a_reg[W-1] == b_reg[W-1]) & (sum_reg[W-1] != a_reg[W-1]).
REQ-013 In DONE, the block SHALL behave as follows:
- out_valid = 1.
- out_sum, out_co and out_ovf are held stable until out_ready = 1.
- On out_valid & out_ready, the FSM moves DONE->IDLE.
REQ-014 Outside DONE, out_valid SHALL be 0 and out_sum, out_co and out_ovf SHALL hold their last values.
REQ-015 Outside RUN, slice_a, slice_b and slice_ci SHALL be driven to 0.
REQ-016 in_valid asserted in RUN or DONE SHALL be ignored and SHALL NOT alter the latched operands.
REQ-017 Back-to-back operation: an input may be accepted in the cycle after the DONE->IDLE transition; no combinational path SHALL exist from out_ready to in_ready.
REQ-018 Operand values SHALL NOT change the cycle count; every addition SHALL take exactly Slices RUN cycles.

Reset
REQ-019 When rst_n = 0 at a clock edge, the block SHALL reset as follows, regardless of state:
- FSM -> IDLE.
- cnt, carry_reg, a_reg, b_reg and sum_reg -> 0.
- out_sum = 0, out_co = 0, out_ovf = 0, out_valid = 0, busy = 0.
- in_ready = 1 in the first cycle after reset is released.
REQ-020 Reset asserted in RUN or DONE SHALL discard the in-flight operation without producing an out_valid pulse.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, each with a behavioural slice adder model attached to the slice ports:
- in_a=0xFFFFFFFF, in_b=0x00000001, in_ci=0 -> out_sum=0x00000000, out_co=1, out_ovf=0, out_valid at cycle 5 after accept.
- in_a=0x7FFFFFFF, in_b=0x00000001, in_ci=0 -> out_sum=0x80000000, out_co=0, out_ovf=1.
- in_a=0x000000FF, in_b=0x00000000, in_ci=1 -> out_sum=0x00000100, out_co=0; slice_ci=1 on the second RUN cycle.
- Result ready with out_ready held 0 for 3 cycles -> out_valid and out_sum stable throughout, in_ready=0, a new in_valid ignored; out_ready=1 -> IDLE, then the next operand is accepted one cycle later.
- rst_n=0 during RUN cycle 2 -> next cycle: busy=0, in_ready=1, out_valid=0, out_sum=0; no stale result ever appears.
- Random 1000 operand pairs with random out_ready stalls -> {out_co, out_sum} == in_a + in_b + in_ci every transaction, and out_ovf matches the signed-overflow reference.
